median3x3_ctrl: RTL and testbench

MEDIAN3X3_CTRL -- requirements
Module: median3x3_ctrl

---
 rtl/median3x3_ctrl.sv | 179 +++++++++++++++++
 tb/tb_median3x3_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median3x3_ctrl.sv
// 3x3 window controller for an external median filter.
// Tracks raster position, keeps two previous rows in line buffers, presents a
// registered 3x3 window and registers the returned median with a
// valid/ready output stage that backpressures the pixel input.
module median3x3_ctrl #(
    parameter int WIDTH  = 16,
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int AWIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [WIDTH+1:0]         in_data,
    output logic                     in_ready,
    output logic [9*(WIDTH+2)-1:0]   win_bus,
    input  logic [WIDTH+1:0]         med_in,
    output logic                     out_valid,
    output logic [WIDTH+1:0]         out_data,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic                     err_sync
);
    localparam int PW    = WIDTH + 2;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = 2 ** AWIDTH;

    localparam logic [AWIDTH-1:0] COL_LAST = AWIDTH'(IMG_W - 1);
    localparam logic [AWIDTH-1:0] COL_TWO  = AWIDTH'(2);
    localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0]     ROW_ONE  = RW'(1);
    localparam logic [RW-1:0]     ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [AWIDTH-1:0]   r_col;
    logic [RW-1:0]       r_row;
    logic                r_s1_v;
    logic                r_out_valid;
    logic [PW-1:0]       r_out_data;
    logic                r_frame_done;
    logic                r_err_sync;
    logic [PW-1:0]       r_win [0:8];
    logic [PW-1:0]       r_lb1 [0:DEPTH-1];
    logic [PW-1:0]       r_lb2 [0:DEPTH-1];

    logic                w_advance;
    logic                w_accept;
    logic                w_take;
    logic [AWIDTH-1:0]   w_pcol;
    logic [RW-1:0]       w_prow;
    logic                w_col_end;
    logic                w_row_end;
    logic [PW-1:0]       w_lb1_rd;
    logic [PW-1:0]       w_lb2_rd;
    logic                w_done_next;
    logic                w_err_next;
    logic                w_unused_flags;

    // Output stage can take a new value when empty or being drained.
    assign w_advance = ~r_out_valid | out_ready;
    assign in_ready  = w_advance;
    assign w_accept  = in_valid & w_advance;
    // Pixels outside a frame are swallowed unless they start one.
    assign w_take    = w_accept & ((r_state != IDLE) | in_sof);

    // A start-of-frame pixel is always position (0,0), whatever the counters say.
    assign w_pcol    = in_sof ? '0 : r_col;
    assign w_prow    = in_sof ? '0 : r_row;
    assign w_col_end = (w_pcol == COL_LAST);
    assign w_row_end = (w_prow == ROW_LAST);

    assign w_lb1_rd  = r_lb1[w_pcol];
    assign w_lb2_rd  = r_lb2[w_pcol];

    assign w_unused_flags = ^med_in[WIDTH+1:WIDTH];

    // Next-state and pulse decode for the frame tracker.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        if (w_take) begin
            if (in_sof && (r_state != IDLE) && ((r_row != '0) || (r_col != '0)))
                w_err_next = 1'b1;
            if (w_col_end && w_row_end) begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
            end else if (w_col_end && (w_prow == ROW_ONE)) begin
                w_state_next = RUN;
            end else if (in_sof) begin
                w_state_next = FILL;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Raster position of the next expected pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_take) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : w_prow + ROW_ONE;
            end else begin
                r_col <= w_pcol + AWIDTH'(1);
                r_row <= w_prow;
            end
        end
    end

    // Line buffers: row r-1 moves down into row r-2 as the new pixel lands.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb1[w_pcol] <= in_data;
            r_lb2[w_pcol] <= w_lb1_rd;
        end
    end

    // 3x3 window shift register; right column gets the newest column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else if (w_take) begin
            for (int r = 0; r < 3; r++) begin
                r_win[3*r]   <= r_win[3*r+1];
                r_win[3*r+1] <= r_win[3*r+2];
            end
            r_win[2] <= w_lb2_rd;
            r_win[5] <= w_lb1_rd;
            r_win[8] <= in_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_taps
            assign win_bus[gi*PW +: PW] = r_win[gi];
        end
    endgenerate

    // Pipeline: window-valid flag, then registered median output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_advance) begin
            r_s1_v      <= w_take & (w_prow >= ROW_TWO) & (w_pcol >= COL_TWO);
            r_out_valid <= r_s1_v;
            r_out_data  <= {2'b00, med_in[WIDTH-1:0]};
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_err_sync   <= 1'b0;
        end else begin
            r_frame_done <= w_done_next;
            r_err_sync   <= w_err_next;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign frame_done = r_frame_done;
    assign err_sync   = r_err_sync;
endmodule

// File: tb/tb_median3x3_ctrl.sv
// Scoreboard bench for median3x3_ctrl on a 5x4 image.
module tb_median3x3_ctrl;
    localparam int W  = 16;
    localparam int PW = W + 2;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic [PW-1:0]     in_data;
    logic              in_ready;
    logic [9*PW-1:0]   win_bus;
    logic [PW-1:0]     med_in;
    logic              out_valid;
    logic [PW-1:0]     out_data;
    logic              out_ready;
    logic              frame_done;
    logic              err_sync;

    median3x3_ctrl #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_ready(in_ready), .win_bus(win_bus),
        .med_in(med_in), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .frame_done(frame_done), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    // External median filter stand-in: sorts the 9 payloads; flags set to 11
    // so the controller's flag clearing is observable.
    function automatic logic [W-1:0] sort_median(input logic [9*PW-1:0] b);
        logic [W-1:0] v [9];
        logic [W-1:0] t;
        for (int i = 0; i < 9; i++) v[i] = b[i*PW +: W];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return v[4];
    endfunction
    assign med_in = {2'b11, sort_median(win_bus)};

    // Reference model state.
    logic [PW-1:0] img [IH][IW];
    logic [PW-1:0] sb [$];
    int m_act = 0, m_r = 0, m_c = 0;
    int exp_done = 0, exp_err = 0, seen_done = 0, seen_err = 0;
    int total = 0, bad = 0;
    int or_mode = 0;
    int n_out = 0;

    // Median by rank: value with <=4 strictly smaller and >=5 not larger.
    function automatic logic [W-1:0] ref_median(input int r, input int c);
        logic [W-1:0] v [9];
        int lt, le;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[3*i+j] = img[r-2+i][c-2+j][W-1:0];
        for (int a = 0; a < 9; a++) begin
            lt = 0; le = 0;
            for (int b = 0; b < 9; b++) begin
                if (v[b] <  v[a]) lt++;
                if (v[b] <= v[a]) le++;
            end
            if (lt <= 4 && le >= 5) return v[a];
        end
        return '0;
    endfunction

    task automatic model_accept(input logic [PW-1:0] d, input logic s);
        if (!m_act && !s) return;
        if (s) begin
            if (m_act != 0 && !(m_r == 0 && m_c == 0)) exp_err++;
            m_act = 1; m_r = 0; m_c = 0;
        end
        img[m_r][m_c] = d;
        if (m_r >= 2 && m_c >= 2) sb.push_back({2'b00, ref_median(m_r, m_c)});
        if (m_c == IW - 1) begin
            m_c = 0;
            if (m_r == IH - 1) begin m_r = 0; m_act = 0; exp_done++; end
            else m_r++;
        end else begin
            m_c++;
        end
    endtask

    task automatic tick(input logic v, input logic [PW-1:0] d, input logic s, output logic acc);
        @(negedge clk);
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        in_valid = v; in_data = d; in_sof = s;
        #1;
        acc = v & in_ready;
        if (acc) model_accept(d, s);
    endtask

    task automatic send(input logic [PW-1:0] d, input logic s);
        logic acc;
        int guard;
        acc = 1'b0; guard = 0;
        if (or_mode == 2 && $urandom_range(0, 3) == 0) tick(1'b0, '0, 1'b0, acc);
        acc = 1'b0;
        while (!acc && guard < 100) begin
            tick(1'b1, d, s, acc);
            guard++;
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
        end
    endtask

    // kind 0: 10*row+col, 1: random, 2: impulse noise on constant 5
    task automatic send_frame(input int kind, input int npix, input logic sof_first);
        logic [PW-1:0] d;
        int r, c;
        for (int i = 0; i < npix; i++) begin
            r = i / IW; c = i % IW;
            case (kind)
                0: d = PW'(10 * r + c);
                1: d = PW'($urandom);
                default: begin
                    d[W-1:0]    = (r == 1 && c == 2) ? 16'hFFFF : 16'd5;
                    d[PW-1:W]   = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
                end
            endcase
            send(d, sof_first && i == 0);
        end
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) send(PW'($urandom), 1'b0);
    endtask

    task automatic drain();
        logic acc;
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            tick(1'b0, '0, 1'b0, acc);
            guard++;
        end
        repeat (3) tick(1'b0, '0, 1'b0, acc);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected outputs never appeared, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (out_valid !== 1'b0 || win_bus !== '0 || frame_done !== 1'b0 ||
            err_sync !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL %s: out_valid=%0b out_data=%h win_bus_zero=%0b frame_done=%0b err_sync=%0b, required all 0",
                     tag, out_valid, out_data, (win_bus == '0), frame_done, err_sync);
        end else begin
            $display("reset check %s ok", tag);
        end
    endtask

    // Monitor: pops expected medians whenever the output handshake occurs.
    initial begin
        logic [PW-1:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0) begin
                if (frame_done === 1'b1) seen_done++;
                if (err_sync === 1'b1)   seen_err++;
                total++;
                if (in_ready !== (!out_valid || out_ready)) begin
                    bad++;
                    $display("FAIL in_ready: got %0b, required %0b (out_valid=%0b out_ready=%0b)",
                             in_ready, (!out_valid || out_ready), out_valid, out_ready);
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_output: got %h, required no output", out_data);
                    end else begin
                        exp = sb.pop_front();
                        n_out++;
                        if (out_data !== exp) begin
                            bad++;
                            $display("FAIL out_data #%0d: got %h, required %h", n_out, out_data, exp);
                        end else begin
                            $display("out #%0d data=%h ok", n_out, out_data);
                        end
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int outs_before;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("power_on");
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;

        // Ramp frame, free-flowing output.
        or_mode = 0; outs_before = n_out;
        send_frame(0, IW * IH, 1'b1);
        drain();
        total++;
        if (n_out - outs_before != 6) begin
            bad++; $display("FAIL ramp_count: got %0d outputs, required 6", n_out - outs_before);
        end

        // Same frame with toggling out_ready.
        or_mode = 1; outs_before = n_out;
        send_frame(0, IW * IH, 1'b1);
        drain();
        total++;
        if (n_out - outs_before != 6) begin
            bad++; $display("FAIL toggle_count: got %0d outputs, required 6", n_out - outs_before);
        end

        // Junk without sof while idle, then a valid frame.
        or_mode = 0; outs_before = n_out;
        send_junk(4);
        send_frame(0, IW * IH, 1'b1);
        drain();
        total++;
        if (n_out - outs_before != 6) begin
            bad++; $display("FAIL idle_junk_count: got %0d outputs, required 6", n_out - outs_before);
        end

        // Truncated frame up to (2,2), new sof arrives at (2,3).
        send_frame(1, 2 * IW + 3, 1'b1);
        send_frame(0, IW * IH, 1'b1);
        drain();

        // Reset after accepting (2,3), then a fresh frame.
        send_frame(0, 2 * IW + 4, 1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        sb.delete(); m_act = 0; m_r = 0; m_c = 0;
        #1;
        check_reset_outputs("mid_frame");
        @(negedge clk);
        rst = 1'b0;
        outs_before = n_out;
        send_frame(0, IW * IH, 1'b1);
        drain();
        total++;
        if (n_out - outs_before != 6) begin
            bad++; $display("FAIL after_reset_count: got %0d outputs, required 6", n_out - outs_before);
        end

        // Impulse noise frame: every median must be 5 with cleared flags.
        send_frame(2, IW * IH, 1'b1);
        drain();

        // Random frames with random gaps and backpressure.
        or_mode = 2;
        for (int f = 0; f < 4; f++) send_frame(1, IW * IH, 1'b1);
        drain();

        total++;
        if (seen_done != exp_done) begin
            bad++; $display("FAIL frame_done_count: got %0d, required %0d", seen_done, exp_done);
        end
        total++;
        if (seen_err != exp_err) begin
            bad++; $display("FAIL err_sync_count: got %0d, required %0d", seen_err, exp_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
